msgfin_read_ctrl: RTL
=====================

// Module: msgfin_read_ctrl
// PURPOSE
//  Sequences the final hard-decision readout after LDPC decoding completes.
//  Sweeps all APP RAM layers in one unbroken burst to drive the get_msgfin
//  sign-collector, then captures its one-cycle-valid Zc-bit word.
//  Presents the word downstream on a valid/ready handshake; no new sweep
//  starts until the previous word has been accepted.
// PARAMETERS
//  DEPTH    128   APP RAM layers per sweep (= APPRam_depth)
//  ADDR_W   7     layer address width (= APP_addr_width-1); 2**ADDR_W >= DEPTH
//  ZC       4096  message width (= Zc)
//  CAP_LAT  3     cycles from last app_en to get_msgfin data_out valid
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: decode finished, begin readout
//  abort      in   1       synchronous cancel of an in-progress readout
//  app_addr   out  ADDR_W  layer address to APP RAM / get_msgfin addr_in
//  app_en     out  1       read enable to APP RAM / get_msgfin en_in
//  fin_data   in   ZC      get_msgfin data_out
//  msg_data   out  ZC      captured decoded message
//  msg_valid  out  1       msg_data holds an unconsumed word
//  msg_ready  in   1       downstream accepts msg_data
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse in the cycle msg_valid first rises
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, app_addr=0, app_en=0,
//   msg_data=0, msg_valid=0, busy=0, done=0. All outputs are registered.
//  States: IDLE, WAIT_BUF, READ, DRAIN.
//  IDLE: on start, go to READ if the buffer is free, else go to WAIT_BUF.
//   Buffer free = !msg_valid | msg_ready. Start is ignored in any other state.
//  WAIT_BUF: app_en=0. Go to READ once the buffer is free.
//  READ: cnt runs 0..DEPTH-1, one layer per cycle. Each cycle drives
//   app_en=1, app_addr=cnt.
//   - Burst is contiguous and may not stall; get_msgfin clears on any en gap.
//   - After cnt=DEPTH-1, go to DRAIN with app_en=0, app_addr=0, cnt=0.
//  DRAIN: cnt counts 0..CAP_LAT-1 with app_en=0.
//   - Cycle numbering: first app_en=1 is cycle 0. Capture edge is the end of
//     cycle DEPTH+CAP_LAT-1 (cnt=CAP_LAT-1).
//   - At that edge: msg_data<=fin_data, msg_valid<=1, done<=1, go to IDLE.
//   - msg_valid is therefore high from cycle DEPTH+CAP_LAT.
//   - fin_data is sampled in no other cycle.
//  Handshake: msg_valid&msg_ready clears msg_valid next cycle.
//   - msg_data holds its value until the next capture.
//   - msg_data is stable while msg_valid=1 and msg_ready=0.
//  Simultaneous events:
//   - abort beats start.
//   - start in IDLE with msg_valid&msg_ready: the word is accepted and READ
//     is entered in the same cycle.
//   - The capture edge never coincides with a pending word; WAIT_BUF
//     guarantees this.
//  Abort in WAIT_BUF/READ/DRAIN: next cycle state=IDLE, app_en=0, cnt=0.
//   No capture and no done; msg_valid/msg_data are unaffected.
//  Async reset mid-sweep: immediate return to reset values. Any pending word
//   is discarded.
//  Counter widths: cnt is max(ADDR_W, clog2(CAP_LAT)) bits. app_addr never
//   exceeds DEPTH-1 (no wrap).
// TESTING
//  1. Reset, start at cycle 0 -> app_en=1 for cycles 1..128 (addr 0..127).
//     msg_valid=1 and done=1 at cycle 132; msg_data = fin_data of cycle 131.
//  2. Model get_msgfin with a pattern -> msg_data == 4096'hA5..A5.
//     Then msg_ready=1 -> msg_valid=0 next cycle.
//  3. msg_valid=1, msg_ready=0, start -> WAIT_BUF, app_en stays 0.
//     Raise msg_ready after 10 cycles -> READ starts that cycle; msg_data
//     is unchanged until the new capture.
//  4. abort at addr 50 -> app_en=0 next cycle, busy=0.
//     No done; previous msg_data/msg_valid are preserved.
//  5. start during READ -> ignored: exactly 128 enables, one done.
//     start and abort together in IDLE -> stays IDLE.
//  6. rst_n low at addr 64 -> all outputs 0 immediately.
//     A later start gives a normal sweep with 128 contiguous app_en cycles.

Source files
------------

// File: rtl/msgfin_read_ctrl.sv
// Final hard-decision readout sequencer: sweeps every APP RAM layer in one burst,
// captures the get_msgfin word and holds it on a valid/ready output.
//
// state    | meaning
// IDLE     | no readout in progress; waits for start
// WAIT_BUF | start seen, previous word not yet accepted
// READ     | contiguous app_en burst over layers 0..DEPTH-1
// DRAIN    | waits out get_msgfin latency, then captures fin_data
module msgfin_read_ctrl #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int ZC      = 4096,
  parameter int CAP_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_en,
  input  logic [ZC-1:0]     fin_data,
  output logic [ZC-1:0]     msg_data,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic              busy,
  output logic              done
);

  localparam int CAP_W = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;
  localparam int CNT_W = (ADDR_W > CAP_W) ? ADDR_W : CAP_W;
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(CAP_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUF, READ, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             buf_free;

  // A pending word that is being accepted this cycle counts as a free buffer.
  assign buf_free = !msg_valid || msg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      app_addr  <= '0;
      app_en    <= 1'b0;
      msg_data  <= '0;
      msg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (msg_valid && msg_ready)
        msg_valid <= 1'b0;

      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        app_en   <= 1'b0;
        app_addr <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              busy     <= 1'b1;
              cnt      <= '0;
              app_addr <= '0;
              if (buf_free) begin
                state  <= READ;
                app_en <= 1'b1;
              end else begin
                state  <= WAIT_BUF;
              end
            end
          end
          WAIT_BUF: begin
            if (buf_free) begin
              state    <= READ;
              app_en   <= 1'b1;
              app_addr <= '0;
              cnt      <= '0;
            end
          end
          READ: begin
            // get_msgfin clears on any enable gap, so the burst never stalls.
            if (cnt == READ_LAST) begin
              state    <= DRAIN;
              app_en   <= 1'b0;
              app_addr <= '0;
              cnt      <= '0;
            end else begin
              cnt      <= cnt + 1'b1;
              app_addr <= ADDR_W'(cnt + 1'b1);
            end
          end
          DRAIN: begin
            if (cnt == DRAIN_LAST) begin
              msg_data  <= fin_data;
              msg_valid <= 1'b1;
              done      <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
